// File: rtl/ks_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ks_pkg
// Brief   : Shared constants and stage payload record for the Kogge-Stone pipe.
// Revision: 1.0
// ============================================================================
package ks_pkg;

    localparam int WIDTH  = 16;
    localparam int LEVELS = 4;
    localparam int SPAN_TABLE [0:LEVELS-1] = '{1, 2, 4, 8};

    // One pipeline stage: running prefix (g, p) plus the untouched P and Cin
    // that the final sum needs.
    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] p_orig;
        logic             cin;
        logic             valid;
    } stage_t;

endpackage
`default_nettype wire

// File: rtl/ks_black_cell.sv
`default_nettype none
// ============================================================================
// Module  : ks_black_cell
// Brief   : Kogge-Stone prefix operator combining bit i with bit i-span.
// Revision: 1.0
// ============================================================================
module ks_black_cell (
    input  logic gi,
    input  logic pi,
    input  logic gj,
    input  logic pj,
    output logic g,
    output logic p
);

    assign g = gi | (pi & gj);
    assign p = pi & pj;

endmodule
`default_nettype wire

// File: rtl/ks_prefix_pipe.sv
`default_nettype none
// ============================================================================
// Module  : ks_prefix_pipe
// Brief   : 4-stage valid/ready pipelined Kogge-Stone carry prefix and sum.
// Revision: 1.0
// ============================================================================
module ks_prefix_pipe #(
    parameter int WIDTH = ks_pkg::WIDTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] G,
    input  logic [WIDTH-1:0] P,
    input  logic             Cin,
    input  logic             In_valid,
    output logic             In_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Out_valid,
    input  logic             Out_ready
);
    import ks_pkg::*;

    stage_t [LEVELS-1:0] stage_q;
    stage_t              fold_w;
    stage_t              last_w;
    logic   [LEVELS-1:0] ready_w;
    logic                unused_w;

    // Carry-in is folded into bit 0 so the prefix tree sees a plain G/P row.
    always_comb begin
        fold_w        = '0;
        fold_w.g      = G;
        fold_w.g[0]   = G[0] | (P[0] & Cin);
        fold_w.p      = P;
        fold_w.p_orig = P;
        fold_w.cin    = Cin;
        fold_w.valid  = In_valid;
    end

    always_comb begin
        ready_w           = '0;
        ready_w[LEVELS-1] = ~stage_q[LEVELS-1].valid | Out_ready;
        for (int l = LEVELS - 2; l >= 0; l--) begin
            ready_w[l] = ~stage_q[l].valid | ready_w[l+1];
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_level
        localparam int SPAN = SPAN_TABLE[l];

        stage_t           lvl_in_w;
        stage_t           stage_d;
        logic [WIDTH-1:0] g_w;
        logic [WIDTH-1:0] p_w;

        if (l == 0) begin : g_src_input
            assign lvl_in_w = fold_w;
        end else begin : g_src_stage
            assign lvl_in_w = stage_q[l-1];
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= SPAN) begin : g_cell
                ks_black_cell u_cell (
                    .gi (lvl_in_w.g[i]),
                    .pi (lvl_in_w.p[i]),
                    .gj (lvl_in_w.g[i-SPAN]),
                    .pj (lvl_in_w.p[i-SPAN]),
                    .g  (g_w[i]),
                    .p  (p_w[i])
                );
            end else begin : g_pass
                assign g_w[i] = lvl_in_w.g[i];
                assign p_w[i] = lvl_in_w.p[i];
            end
        end

        always_comb begin
            stage_d   = lvl_in_w;
            stage_d.g = g_w;
            stage_d.p = p_w;
        end

        // Loading while upstream is empty inserts a bubble (valid=0).
        always_ff @(posedge Clk) begin
            if (Rst) begin
                stage_q[l] <= '0;
            end else if (ready_w[l]) begin
                stage_q[l] <= stage_d;
            end
        end
    end

    assign last_w    = stage_q[LEVELS-1];
    assign Sum       = last_w.p_orig ^ {last_w.g[WIDTH-2:0], last_w.cin};
    assign Cout      = last_w.g[WIDTH-1];
    assign Out_valid = last_w.valid;
    assign In_ready  = ~Rst & ready_w[0];
    assign unused_w  = ^last_w.p;

endmodule
`default_nettype wire

// File: tb/tb_ks_prefix_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_ks_prefix_pipe
// Brief   : Randomized and directed checks of ks_prefix_pipe against A+B+Cin.
// Revision: 1.0
// ============================================================================
module tb_ks_prefix_pipe;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [15:0] G;
    logic [15:0] P;
    logic        Cin;
    logic        In_valid;
    logic        In_ready;
    logic [15:0] Sum;
    logic        Cout;
    logic        Out_valid;
    logic        Out_ready;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          n_out = 0;
    int          n_in  = 0;
    bit          lat_en = 1'b0;
    logic [16:0] exp_q[$];
    int          acc_q[$];
    logic [17:0] obs_out;
    logic        obs_in_ready;

    ks_prefix_pipe #(.WIDTH(16)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .G         (G),
        .P         (P),
        .Cin       (Cin),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive operands A/B (as G=A&B, P=A^B), observe at negedge.
    task automatic step(input logic iv, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic ordy);
        logic [16:0] e;
        int          acc;
        In_valid  = iv;
        G         = a & b;
        P         = a ^ b;
        Cin       = ci;
        Out_ready = ordy;
        @(negedge Clk);
        obs_out      = {Out_valid, Cout, Sum};
        obs_in_ready = In_ready;
        if (Out_valid && Out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check_val("spurious_out", 32'(1), 32'(0));
            end else begin
                e   = exp_q.pop_front();
                acc = acc_q.pop_front();
                check_val("result", 32'({Cout, Sum}), 32'(e));
                if (lat_en) check_val("latency", 32'(cyc - acc), 32'(4));
            end
        end
        if (In_valid && In_ready) begin
            n_in++;
            exp_q.push_back({1'b0, a} + {1'b0, b} + {16'b0, ci});
            acc_q.push_back(cyc);
        end
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        Rst       = 1'b1;
        In_valid  = 1'b0;
        Out_ready = 1'b0;
        @(posedge Clk);
        #1;
        cyc++;
        @(negedge Clk);
        check_val("rst_out_valid", 32'(Out_valid), 32'(0));
        check_val("rst_sum_cout", 32'({Cout, Sum}), 32'(0));
        check_val("rst_in_ready", 32'(In_ready), 32'(0));
        @(posedge Clk);
        #1;
        cyc++;
        Rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        @(negedge Clk);
        check_val("post_rst_in_ready", 32'(In_ready), 32'(1));
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          o0;
        int          i0;
        int          guard;
        logic [17:0] snap;

        Rst = 1'b1; In_valid = 1'b0; G = '0; P = '0; Cin = 1'b0; Out_ready = 1'b0;
        snap = '0;
        do_reset();

        // 0xFFFF + 0x0001 wraps to 0 with carry-out, single output cycle.
        lat_en = 1'b1;
        o0 = n_out;
        step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        idle(6);
        check_val("single_out_count", 32'(n_out - o0), 32'(1));

        // Carry-in propagating through all-ones, and carry-in alone.
        o0 = n_out;
        step(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
        step(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1);
        idle(6);
        check_val("cin_out_count", 32'(n_out - o0), 32'(2));

        // Back-to-back stream with the sink always ready.
        o0 = n_out;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            check_val("b2b_in_ready", 32'(obs_in_ready), 32'(1));
        end
        idle(6);
        check_val("b2b_out_count", 32'(n_out - o0), 32'(8));

        // Stalled sink: pipe absorbs four, then holds its head result.
        lat_en = 1'b0;
        i0 = n_in;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            if (k == 5) snap = obs_out;
        end
        check_val("stall_accepted", 32'(n_in - i0), 32'(4));
        check_val("stall_in_ready", 32'(obs_in_ready), 32'(0));
        check_val("stall_stable", 32'(obs_out), 32'(snap));
        check_val("stall_valid", 32'(snap[17]), 32'(1));
        check_val("stall_head", 32'(snap[16:0]), 32'(exp_q[0]));
        o0 = n_out;
        idle(8);
        check_val("release_out_count", 32'(n_out - o0), 32'(4));
        check_val("release_drained", 32'(exp_q.size()), 32'(0));

        // Reset with three results in flight; nothing stale may emerge.
        lat_en = 1'b1;
        for (int k = 0; k < 3; k++)
            step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        do_reset();
        o0 = n_out;
        idle(6);
        check_val("flush_out_count", 32'(n_out - o0), 32'(0));
        o0 = n_out;
        step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        idle(6);
        check_val("post_flush_count", 32'(n_out - o0), 32'(1));

        // Random traffic with random back-pressure.
        lat_en = 1'b0;
        i0 = n_in;
        guard = 0;
        while ((n_in - i0) < 10000 && guard < 60000) begin
            step(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            guard++;
        end
        check_val("rand_accept_budget", 32'(n_in - i0), 32'(10000));
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            guard++;
        end
        check_val("rand_drained", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ks_prefix_pipe.md
KS_PREFIX_PIPE -- requirements
Module: ks_prefix_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named Clk and Rst as the codebase does.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Rst  input  1  synchronous active-high reset, sampled on the Clk rising edge.
REQ-004 G  input  16  per-bit generate vector (Ai AND Bi) from the GP cell row.
REQ-005 P  input  16  per-bit propagate vector (Ai XOR Bi) from the GP cell row.
REQ-006 Cin  input  1  carry-in.
REQ-007 In_valid  input  1  G/P/Cin are valid this cycle.
REQ-008 In_ready  output  1  block accepts the input this cycle.
REQ-009 Sum  output  16  sum result.
REQ-010 Cout  output  1  carry-out.
REQ-011 Out_valid  output  1  Sum/Cout are valid.
REQ-012 Out_ready  input  1  consumer accepts the output this cycle.
REQ-013 Parameter WIDTH, default 16, is the operand width; only 16 is supported and verified.

Function
REQ-014 An input transfer SHALL occur on a cycle with In_valid=1 and In_ready=1; an output transfer SHALL occur on a cycle with Out_valid=1 and Out_ready=1.
REQ-015 On acceptance the block SHALL fold Cin into bit 0: g0' = G[0] | (P[0] & Cin), p0' = P[0]; all other bits pass unchanged.
REQ-016 The block SHALL compute the Kogge-Stone prefix in 4 levels with span 1, 2, 4 and 8. At each level and bit i >= span: g = g_i | (p_i & g_{i-span}) and p = p_i & p_{i-span}. Bits i < span pass through unchanged.
REQ-017 Each prefix level SHALL be followed by a pipeline register, giving 4 register stages. The original P vector and Cin SHALL travel alongside each stage.
REQ-018 Output stage: carry c0 = Cin and ci = Gpre[i-1] for i = 1..15; Sum[i] = P[i] ^ ci; Cout = Gpre[15].
REQ-019 Latency SHALL be exactly 4 cycles from input transfer to Out_valid when Out_ready is held at 1. Throughput SHALL be 1 result per cycle with no bubbles.
REQ-020 Each stage SHALL hold its own valid bit. A stage loads when it is empty or its contents move downstream this cycle; otherwise it holds its value.
REQ-021 In_ready SHALL equal (stage-1 empty) OR (stage 1 advancing), with readiness propagated combinationally from Out_ready. The block SHALL contain no combinational path from In_valid to In_ready.
REQ-022 While Out_ready=0 with the pipeline full, Sum/Cout/Out_valid SHALL hold stable and In_ready SHALL be 0. The pipe SHALL absorb up to 4 results before stalling.
REQ-023 Simultaneous input and output transfers SHALL both take effect in the same cycle, with no loss or duplication.
REQ-024 Results SHALL leave the block in acceptance order.
REQ-025 Inputs with G&P nonzero are out of contract but SHALL be computed by the formulas above without error.
REQ-026 Arithmetic SHALL be modulo 2^16 on Sum, with the overflow reported only through Cout.

Reset
REQ-027 When Rst=1 on a clock edge, all stage valid bits SHALL clear, Out_valid=0, and Sum=0, Cout=0 on the following cycle.
REQ-028 In_ready SHALL be 0 while Rst=1 and 1 on the first cycle after Rst deasserts.
REQ-029 A reset mid-operation SHALL discard all in-flight results; none SHALL appear after reset.
REQ-030 Data registers other than the outputs need not be reset.

Structure
REQ-031 A shared package ks_pkg SHALL hold WIDTH=16, LEVELS=4, the span table {1,2,4,8}, and the typedef for the stage payload record (g, p, P_orig, Cin, valid).
REQ-032 The prefix operator SHALL be a sub-module ks_black_cell (inputs gi, pi, gj, pj; outputs g, p), instantiated per bit per level.
REQ-033 All state SHALL sit in one clocked process per stage; there SHALL be no latches and no second clock.

Verification
REQ-034 G=0x0001, P=0xFFFE, Cin=0 (0xFFFF+0x0001), Out_ready=1 -> after 4 cycles Sum=0x0000, Cout=1, Out_valid=1 for 1 cycle.
REQ-035 G=0x0000, P=0xFFFF, Cin=1 -> Sum=0x0000, Cout=1; and G=0, P=0, Cin=1 -> Sum=0x0001, Cout=0.
REQ-036 8 back-to-back inputs with Out_ready=1 -> 8 consecutive Out_valid cycles beginning on cycle 4, in order, In_ready constantly 1.
REQ-037 Out_ready=0 for 10 cycles while feeding inputs -> exactly 4 accepted, In_ready=0 afterwards, outputs stable. After release -> 4 results in order with no drops.
REQ-038 Rst pulsed with 3 results in flight -> Out_valid=0 on the next cycle and no stale result ever appears; the next input yields its correct result at latency 4.
REQ-039 10k random A/B/Cin (G=A&B, P=A^B) with random Out_ready and In_valid -> every {Cout,Sum} equals A+B+Cin, in order.
